deser_align_multi: RTL and testbench

- Parametrised, multi-channel successor to the two-lane serial-to-parallel stage.
- Each channel receives BPC pre-sampled bits per clock, already deskewed to the system clock.
- Per channel, the block finds word alignment by hunting for a programmable sync word, then assembles WIDTH-bit words and strobes them out.
- It tracks lock per channel and drops back to hunting when sync words stop arriving.
- Sits between the sampling front end and the readout FIFO/event builder.

---
 rtl/deser_align_multi.sv | 175 +++++++++++++++++
 tb/tb_deser_align_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deser_align_multi.sv
// deser_align_multi: per-channel serial-to-parallel stage with sync-word
// alignment, lock tracking and a data-word timeout.
//
// Output strobe semantics: write[c] is a one-cycle strobe with no back-pressure.
// The par_data slice of channel c is valid in the cycle where write[c] is high.
// The slice then holds that value until the next write on that channel.
module deser_align_multi #(
    parameter int               NCH     = 2,
    parameter int               BPC     = 2,
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] SYNC    = 16'hF628,
    parameter int               TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 res,
    input  logic                 run,
    input  logic [NCH*BPC-1:0]   ser_in,
    output logic [NCH*WIDTH-1:0] par_data,
    output logic [NCH-1:0]       write,
    output logic [NCH-1:0]       locked,
    output logic [NCH-1:0]       sync_seen,
    output logic [NCH-1:0]       lock_lost
);

    localparam int SRW = WIDTH + BPC - 1;            // shift register length
    localparam int WPC = WIDTH / BPC;                // clocks per word
    localparam int CW  = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int PW  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int TW  = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [SRW-1:0]   sr_q, sr_d;
        state_t           state_q, state_d;
        logic [PW-1:0]    phase_q, phase_d;
        logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
        logic [TW-1:0]    to_cnt_q, to_cnt_d;
        logic [WIDTH-1:0] par_q, par_d;
        logic             write_q, write_d;
        logic             sync_q, sync_d;
        logic             lost_q, lost_d;
        logic [BPC-1:0]   match;
        logic             any_match;
        logic [PW-1:0]    first_p;
        logic [WIDTH-1:0] cur_word;
        logic             boundary;

        // Newest bits enter at the LSB end; the higher ser_in bit is the older one.
        assign sr_d = {sr_q[SRW-BPC-1:0], ser_in[c*BPC +: BPC]};

        // Compare every candidate window against the sync word.
        always_comb begin
            match = '0;
            for (int p = 0; p < BPC; p++) begin
                match[p] = (sr_q[p +: WIDTH] == SYNC);
            end
        end

        // Pick the lowest matching phase (most recent window wins).
        always_comb begin
            first_p   = '0;
            any_match = 1'b0;
            for (int p = BPC - 1; p >= 0; p--) begin
                if (match[p]) begin
                    first_p   = PW'(p);
                    any_match = 1'b1;
                end
            end
        end

        // Select the word at the latched alignment phase.
        always_comb begin
            cur_word = sr_q[WIDTH-1:0];
            for (int p = 0; p < BPC; p++) begin
                if (phase_q == PW'(p)) begin
                    cur_word = sr_q[p +: WIDTH];
                end
            end
        end

        assign boundary = (bit_cnt_q == CW'(WPC - 1));

        // Next-state and registered-output logic for the channel FSM.
        always_comb begin
            state_d   = state_q;
            phase_d   = phase_q;
            bit_cnt_d = bit_cnt_q;
            to_cnt_d  = to_cnt_q;
            par_d     = par_q;
            write_d   = 1'b0;
            sync_d    = 1'b0;
            lost_d    = 1'b0;
            if (!run) begin
                // Abort discards any partial word; par_q keeps its last value.
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_d   = ST_SEARCH;
                        bit_cnt_d = '0;
                        to_cnt_d  = '0;
                    end
                    ST_SEARCH: begin
                        if (any_match) begin
                            state_d   = ST_LOCKED;
                            phase_d   = first_p;
                            bit_cnt_d = '0;
                            to_cnt_d  = '0;
                            sync_d    = 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (boundary) begin
                            bit_cnt_d = '0;
                            if (cur_word == SYNC) begin
                                sync_d   = 1'b1;
                                to_cnt_d = '0;
                            end else begin
                                par_d    = cur_word;
                                write_d  = 1'b1;
                                to_cnt_d = to_cnt_q + TW'(1);
                                if ((TIMEOUT != 0) && (to_cnt_q + TW'(1) == TW'(TIMEOUT))) begin
                                    lost_d  = 1'b1;
                                    state_d = ST_SEARCH;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        // State and datapath registers with synchronous active-low reset.
        always_ff @(posedge clock) begin
            if (!res) begin
                sr_q      <= '0;
                state_q   <= ST_IDLE;
                phase_q   <= '0;
                bit_cnt_q <= '0;
                to_cnt_q  <= '0;
                par_q     <= '0;
                write_q   <= 1'b0;
                sync_q    <= 1'b0;
                lost_q    <= 1'b0;
            end else begin
                sr_q      <= sr_d;
                state_q   <= state_d;
                phase_q   <= phase_d;
                bit_cnt_q <= bit_cnt_d;
                to_cnt_q  <= to_cnt_d;
                par_q     <= par_d;
                write_q   <= write_d;
                sync_q    <= sync_d;
                lost_q    <= lost_d;
            end
        end

        assign par_data[c*WIDTH +: WIDTH] = par_q;
        assign write[c]                   = write_q;
        assign locked[c]                  = (state_q == ST_LOCKED);
        assign sync_seen[c]               = sync_q;
        assign lock_lost[c]               = lost_q;
    end

endmodule

// File: tb/tb_deser_align_multi.sv
// Bench for deser_align_multi: bit-stream driver, expected-word scoreboard,
// one task per scenario, single summary line.
module tb_deser_align_multi;

    localparam int               NCH     = 2;
    localparam int               BPC     = 2;
    localparam int               WIDTH   = 16;
    localparam int               TIMEOUT = 64;
    localparam int               WPC     = WIDTH / BPC;
    localparam int               SW      = NCH * BPC;
    localparam logic [WIDTH-1:0] SYNC    = 16'hF628;

    logic                 clock = 1'b0;
    logic                 res;
    logic                 run;
    logic [SW-1:0]        ser_in;
    logic [NCH*WIDTH-1:0] par_data;
    logic [NCH-1:0]       write;
    logic [NCH-1:0]       locked;
    logic [NCH-1:0]       sync_seen;
    logic [NCH-1:0]       lock_lost;

    int checks   = 0;
    int failures = 0;

    logic             bq0[$];
    logic             bq1[$];
    logic [WIDTH-1:0] exp_q[$];

    // Clock
    always #5 clock = ~clock;

    deser_align_multi #(
        .NCH(NCH), .BPC(BPC), .WIDTH(WIDTH), .SYNC(SYNC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock     (clock),
        .res       (res),
        .run       (run),
        .ser_in    (ser_in),
        .par_data  (par_data),
        .write     (write),
        .locked    (locked),
        .sync_seen (sync_seen),
        .lock_lost (lock_lost)
    );

    // ---------------- driver tasks ----------------
    task automatic push_bit(input int ch, input logic v);
        if (ch == 0) bq0.push_back(v);
        else         bq1.push_back(v);
    endtask

    task automatic push_word(input int ch, input logic [WIDTH-1:0] w);
        for (int b = WIDTH - 1; b >= 0; b--) push_bit(ch, w[b]);
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [WIDTH-1:0] w;
        do w = WIDTH'($urandom_range(0, 65535)); while (w == SYNC);
        return w;
    endfunction

    // One clock: earliest queued bit goes to the higher bit of each lane.
    task automatic drive_cycle();
        logic [SW-1:0] v;
        v = '0;
        for (int b = BPC - 1; b >= 0; b--) begin
            if (bq0.size() > 0) v[b]       = bq0.pop_front();
            if (bq1.size() > 0) v[BPC + b] = bq1.pop_front();
        end
        ser_in = v;
        @(posedge clock);
        #1;
    endtask

    // Return both channels to IDLE with a zeroed history, then enter SEARCH.
    task automatic flush();
        run = 1'b0;
        bq0.delete();
        bq1.delete();
        exp_q.delete();
        repeat (10) drive_cycle();
        run = 1'b1;
        drive_cycle();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        res = 1'b0;
        run = 1'b0;
        repeat (3) begin
            ser_in = SW'($urandom);
            @(posedge clock);
            #1;
        end
        checks++; if (write !== '0)     begin failures++; $display("FAIL reset_write: got %b want 0", write); end
        checks++; if (locked !== '0)    begin failures++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (sync_seen !== '0) begin failures++; $display("FAIL reset_sync_seen: got %b want 0", sync_seen); end
        checks++; if (lock_lost !== '0) begin failures++; $display("FAIL reset_lock_lost: got %b want 0", lock_lost); end
        checks++; if (par_data !== '0)  begin failures++; $display("FAIL reset_par_data: got %h want 0", par_data); end
        res = 1'b1;
        repeat (6) begin
            ser_in = SW'($urandom);
            @(posedge clock);
            #1;
            checks++;
            if (write !== '0 || locked !== '0 || par_data !== '0) begin
                failures++;
                $display("FAIL idle_outputs: write=%b locked=%b par=%h want all 0", write, locked, par_data);
            end
        end
    endtask

    // SYNC, 1234, ABCD on channel ch with 'lead' extra bits in front.
    task automatic test_lock_data(input int ch, input int lead);
        int               ks;
        logic             exp_wr;
        logic [WIDTH-1:0] got, want;
        flush();
        for (int b = 0; b < lead; b++) push_bit(ch, 1'b1);
        push_word(ch, SYNC);
        push_word(ch, 16'h1234); exp_q.push_back(16'h1234);
        push_word(ch, 16'hABCD); exp_q.push_back(16'hABCD);
        ks = (lead + WIDTH - 1) / BPC;
        for (int i = 0; i <= ks + 2 * WPC + 1; i++) begin
            drive_cycle();
            exp_wr = (i == ks + WPC + 1) || (i == ks + 2 * WPC + 1);
            checks++; if (write[ch] !== exp_wr) begin failures++; $display("FAIL lock_write_timing ch%0d cyc%0d: got %b want %b", ch, i, write[ch], exp_wr); end
            checks++; if (write[1-ch] !== 1'b0) begin failures++; $display("FAIL other_ch_write ch%0d cyc%0d: got %b want 0", 1-ch, i, write[1-ch]); end
            checks++; if (sync_seen[ch] !== (i == ks + 1)) begin failures++; $display("FAIL lock_sync_seen ch%0d cyc%0d: got %b want %b", ch, i, sync_seen[ch], (i == ks + 1)); end
            checks++; if (locked[ch] !== (i >= ks + 1)) begin failures++; $display("FAIL lock_locked ch%0d cyc%0d: got %b want %b", ch, i, locked[ch], (i >= ks + 1)); end
            if (write[ch] === 1'b1) begin
                got = par_data[ch*WIDTH +: WIDTH];
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL lock_extra_write ch%0d: got %h want none", ch, got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin failures++; $display("FAIL lock_data ch%0d: got %h want %h", ch, got, want); end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lock_missing_words: got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_sync_in_locked();
        logic [WIDTH-1:0] w, want;
        int n_wr, n_sync, n_lost;
        n_wr = 0; n_sync = 0; n_lost = 0;
        flush();
        push_word(0, SYNC);
        repeat (63) begin w = rand_word(); push_word(0, w); exp_q.push_back(w); end
        push_word(0, SYNC);
        repeat (63) begin w = rand_word(); push_word(0, w); exp_q.push_back(w); end
        for (int i = 0; i <= 128 * WPC; i++) begin
            drive_cycle();
            if (sync_seen[0] === 1'b1) n_sync++;
            if (lock_lost[0] === 1'b1) n_lost++;
            if (write[0] === 1'b1) begin
                n_wr++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL sil_extra_write: got %h want none", par_data[WIDTH-1:0]);
                end else begin
                    want = exp_q.pop_front();
                    if (par_data[WIDTH-1:0] !== want) begin failures++; $display("FAIL sil_data: got %h want %h", par_data[WIDTH-1:0], want); end
                end
            end
        end
        checks++; if (n_wr != 126)  begin failures++; $display("FAIL sil_write_count: got %0d want 126", n_wr); end
        checks++; if (n_sync != 2)  begin failures++; $display("FAIL sil_sync_count: got %0d want 2", n_sync); end
        checks++; if (n_lost != 0)  begin failures++; $display("FAIL sil_lock_lost: got %0d want 0", n_lost); end
        checks++; if (locked[0] !== 1'b1) begin failures++; $display("FAIL sil_locked: got %b want 1", locked[0]); end
    endtask

    task automatic test_timeout();
        logic [WIDTH-1:0] w, want;
        int n_wr, n_sync, n_lost;
        n_wr = 0; n_sync = 0; n_lost = 0;
        flush();
        push_word(0, SYNC);
        repeat (64) begin w = rand_word(); push_word(0, w); exp_q.push_back(w); end
        push_word(0, SYNC);
        push_word(0, 16'h5A5A); exp_q.push_back(16'h5A5A);
        for (int i = 0; i <= 67 * WPC; i++) begin
            drive_cycle();
            if (sync_seen[0] === 1'b1) n_sync++;
            if (write[0] === 1'b1) begin
                n_wr++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL to_extra_write: got %h want none", par_data[WIDTH-1:0]);
                end else begin
                    want = exp_q.pop_front();
                    if (par_data[WIDTH-1:0] !== want) begin failures++; $display("FAIL to_data: got %h want %h", par_data[WIDTH-1:0], want); end
                end
            end
            if (lock_lost[0] === 1'b1) begin
                n_lost++;
                checks++;
                if (write[0] !== 1'b1 || locked[0] !== 1'b0 || n_wr != 64) begin
                    failures++;
                    $display("FAIL to_lost_cycle: write=%b locked=%b writes=%0d want 1 0 64", write[0], locked[0], n_wr);
                end
            end
        end
        checks++; if (n_wr != 65)  begin failures++; $display("FAIL to_write_count: got %0d want 65", n_wr); end
        checks++; if (n_lost != 1) begin failures++; $display("FAIL to_lost_count: got %0d want 1", n_lost); end
        checks++; if (n_sync != 2) begin failures++; $display("FAIL to_sync_count: got %0d want 2", n_sync); end
        checks++; if (locked[0] !== 1'b1) begin failures++; $display("FAIL to_relock: got %b want 1", locked[0]); end
    endtask

    task automatic test_abort();
        logic [WIDTH-1:0] want;
        flush();
        push_word(0, SYNC);
        push_word(0, 16'h1357); exp_q.push_back(16'h1357);
        push_word(0, 16'hC3C3);
        for (int i = 0; i <= 20; i++) begin
            drive_cycle();
            if (write[0] === 1'b1) begin
                checks++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
                if (par_data[WIDTH-1:0] !== want) begin failures++; $display("FAIL abort_first_data: got %h want %h", par_data[WIDTH-1:0], want); end
            end
        end
        checks++; if (locked[0] !== 1'b1) begin failures++; $display("FAIL abort_pre_locked: got %b want 1", locked[0]); end
        run = 1'b0;
        drive_cycle();
        checks++; if (locked[0] !== 1'b0) begin failures++; $display("FAIL abort_locked: got %b want 0", locked[0]); end
        for (int i = 0; i < 12; i++) begin
            drive_cycle();
            checks++; if (write[0] !== 1'b0) begin failures++; $display("FAIL abort_partial_write cyc%0d: got %b want 0", i, write[0]); end
        end
        checks++; if (par_data[WIDTH-1:0] !== 16'h1357) begin failures++; $display("FAIL abort_par_hold: got %h want 1357", par_data[WIDTH-1:0]); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL abort_missing_words: got %0d left want 0", exp_q.size()); end
        bq0.delete();
        run = 1'b1;
        drive_cycle();
        push_word(0, SYNC);
        push_word(0, 16'h2468); exp_q.push_back(16'h2468);
        for (int i = 0; i <= 2 * WPC; i++) begin
            drive_cycle();
            checks++; if (write[0] !== (i == 2 * WPC)) begin failures++; $display("FAIL relock_write cyc%0d: got %b want %b", i, write[0], (i == 2 * WPC)); end
            checks++; if (locked[0] !== (i >= WPC)) begin failures++; $display("FAIL relock_locked cyc%0d: got %b want %b", i, locked[0], (i >= WPC)); end
            if (write[0] === 1'b1 && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                checks++; if (par_data[WIDTH-1:0] !== want) begin failures++; $display("FAIL relock_data: got %h want %h", par_data[WIDTH-1:0], want); end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        push_word(0, 16'h0F0F);
        repeat (3) drive_cycle();
        res = 1'b0;
        drive_cycle();
        checks++; if (par_data !== '0) begin failures++; $display("FAIL midrst_par_data: got %h want 0", par_data); end
        checks++; if (locked !== '0 || write !== '0 || sync_seen !== '0 || lock_lost !== '0) begin
            failures++; $display("FAIL midrst_flags: locked=%b write=%b sync=%b lost=%b want 0", locked, write, sync_seen, lock_lost);
        end
        res = 1'b1;
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle();
            checks++; if (write !== '0) begin failures++; $display("FAIL midrst_write cyc%0d: got %b want 0", i, write); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        res    = 1'b0;
        run    = 1'b0;
        ser_in = '0;
        test_reset();
        test_lock_data(0, 0);
        test_lock_data(1, 1);
        test_sync_in_locked();
        test_timeout();
        test_abort();
        test_reset_mid_word();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
